// File: rtl/sdfm_input_ctl_if.sv
// Bundle of modulator pins, channel configuration and recovered-bit outputs
// for one sigma-delta input qualifier channel.
interface sdfm_input_ctl_if;
    logic       DSDIN;
    logic       SDCLK;
    logic [1:0] reg_filtmode;
    logic [3:0] reg_filtdiv;
    logic       reg_filten;
    logic       reg_faultclr;
    logic       bit_data;
    logic       bit_valid;
    logic       MCLK_OUT;
    logic       clk_fault;
    logic       dbg_locked;

    modport master (
        output DSDIN, SDCLK, reg_filtmode, reg_filtdiv, reg_filten, reg_faultclr,
        input  bit_data, bit_valid, MCLK_OUT, clk_fault, dbg_locked
    );

    modport slave (
        input  DSDIN, SDCLK, reg_filtmode, reg_filtdiv, reg_filten, reg_faultclr,
        output bit_data, bit_valid, MCLK_OUT, clk_fault, dbg_locked
    );
endinterface

// File: rtl/sdfm_input_ctl.sv
// Sigma-delta input qualifier: synchronizes DSDIN/SDCLK, recovers one bit per
// modulator bit (rising, falling, Manchester or internal clock) and flags a dead clock.
module sdfm_input_ctl #(
    parameter int TIMEOUT = 255
) (
    input  logic             SYSCLK,
    input  logic             SYSRST,
    sdfm_input_ctl_if.slave  bus
);
    // bit_valid is a one-cycle strobe with no backpressure; bit_data is
    // meaningful only in a cycle where bit_valid is 1.

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_t;

    localparam logic [15:0] TCNT_MAX = 16'(TIMEOUT);

    lock_t       lock_state;
    logic        din_s1, din_s2, din_s3;
    logic        sck_s1, sck_s2, sck_s3;
    logic [1:0]  mode_q;
    logic [6:0]  ecnt;
    logic [3:0]  dcnt;
    logic [15:0] tcnt;
    logic        bit_data_q, bit_valid_q, mclk_q, fault_q;

    logic        clr, rise, fall, dedge, qual, mid_ok;
    logic [3:0]  div_eff;
    logic [6:0]  half7, thresh, ecnt_max;

    assign clr      = SYSRST | ~bus.reg_filten | (bus.reg_filtmode != mode_q);
    assign rise     = sck_s2 & ~sck_s3;
    assign fall     = ~sck_s2 & sck_s3;
    assign dedge    = din_s2 ^ din_s3;
    // Manchester timing uses D=1 when D=0 so the threshold stays above one half-bit.
    assign div_eff  = (bus.reg_filtdiv == 4'd0) ? 4'd1 : bus.reg_filtdiv;
    assign half7    = 7'(div_eff) + 7'd1;
    assign thresh   = 7'((half7 + (half7 << 1)) >> 1);
    assign ecnt_max = half7 << 2;
    assign mid_ok   = (lock_state == UNLOCKED) || (ecnt >= thresh);

    always_comb begin
        qual = 1'b0;
        case (bus.reg_filtmode)
            2'd0:    qual = rise;
            2'd1:    qual = fall;
            2'd2:    qual = dedge;
            default: qual = 1'b0;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRST) begin
            {din_s1, din_s2, din_s3} <= 3'b000;
            {sck_s1, sck_s2, sck_s3} <= 3'b000;
            mode_q <= 2'd0;
        end else begin
            din_s1 <= bus.DSDIN;
            din_s2 <= din_s1;
            din_s3 <= din_s2;
            sck_s1 <= bus.SDCLK;
            sck_s2 <= sck_s1;
            sck_s3 <= sck_s2;
            mode_q <= bus.reg_filtmode;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (clr) begin
            lock_state  <= UNLOCKED;
            ecnt        <= 7'd0;
            dcnt        <= 4'd0;
            tcnt        <= 16'd0;
            bit_data_q  <= 1'b0;
            bit_valid_q <= 1'b0;
            mclk_q      <= 1'b0;
        end else begin
            bit_valid_q <= 1'b0;
            case (bus.reg_filtmode)
                2'd0: if (rise) begin
                    bit_data_q  <= din_s3;
                    bit_valid_q <= 1'b1;
                end
                2'd1: if (fall) begin
                    bit_data_q  <= din_s3;
                    bit_valid_q <= 1'b1;
                end
                2'd2: begin
                    // Edges closer than T to the last accepted one are bit boundaries.
                    if (dedge && mid_ok) begin
                        bit_data_q  <= din_s2;
                        bit_valid_q <= 1'b1;
                        ecnt        <= 7'd0;
                        lock_state  <= LOCKED;
                    end else if (ecnt >= ecnt_max) begin
                        lock_state <= UNLOCKED;
                    end else begin
                        ecnt <= ecnt + 7'd1;
                    end
                end
                default: begin
                    if (dcnt == bus.reg_filtdiv) begin
                        dcnt   <= 4'd0;
                        mclk_q <= ~mclk_q;
                        if (mclk_q) begin
                            bit_data_q  <= din_s2;
                            bit_valid_q <= 1'b1;
                        end
                    end else begin
                        dcnt <= dcnt + 4'd1;
                    end
                end
            endcase

            if (bus.reg_filtmode == 2'd3 || qual)
                tcnt <= 16'd0;
            else if (tcnt < TCNT_MAX)
                tcnt <= tcnt + 16'd1;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (SYSRST || !bus.reg_filten)
            fault_q <= 1'b0;
        else if (bus.reg_filtmode != 2'd3 && tcnt == TCNT_MAX)
            fault_q <= 1'b1;
        else if (bus.reg_faultclr)
            fault_q <= 1'b0;
    end

    assign bus.bit_data   = bit_data_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.MCLK_OUT   = mclk_q;
    assign bus.clk_fault  = fault_q;
    assign bus.dbg_locked = (lock_state == LOCKED);
endmodule

// File: tb/tb_sdfm_input_ctl.sv
// Directed bench for sdfm_input_ctl: expected bits (value and arrival cycle)
// are queued by the drivers and checked by an independent monitor.
module tb_sdfm_input_ctl;
    localparam int TIMEOUT = 16;
    localparam int W = 33;

    logic SYSCLK = 1'b0;
    logic SYSRST;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;

    sdfm_input_ctl_if bus();

    sdfm_input_ctl #(.TIMEOUT(TIMEOUT)) dut (
        .SYSCLK(SYSCLK),
        .SYSRST(SYSRST),
        .bus(bus)
    );

    // clock / reset
    always #5 SYSCLK = ~SYSCLK;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge SYSCLK);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick(1);
    endtask

    // A pin change driven at cycle k reaches bit_valid at cycle k+3.
    task automatic expect_bit(input logic b, input int at);
        exp_q.push_back({b, 32'(at)});
    endtask

    // SDCLK period 8; data changes with each falling edge, MSB of bits first.
    task automatic clk_bits(input int mode, input logic [3:0] bits, input int n, output int last_rise);
        logic b, prev;
        prev = 1'b0;
        last_rise = cyc;
        for (int i = 0; i < n; i++) begin
            b = bits[n-1-i];
            if (mode == 1 && i > 0) expect_bit(prev, cyc + 3);
            bus.SDCLK = 1'b0;
            bus.DSDIN = b;
            tick(4);
            bus.SDCLK = 1'b1;
            last_rise = cyc;
            if (mode == 0) expect_bit(b, cyc + 3);
            tick(4);
            prev = b;
        end
        if (mode == 1) expect_bit(prev, cyc + 3);
        bus.SDCLK = 1'b0;
        tick(4);
    endtask

    // Manchester line levels, 4 cycles per half-bit, MSB first.
    task automatic drive_halves(input logic [7:0] levels, input logic [7:0] accept, input int n);
        for (int h = 0; h < n; h++) begin
            bus.DSDIN = levels[n-1-h];
            if (accept[n-1-h]) expect_bit(levels[n-1-h], cyc + 3);
            tick(4);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick(1);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // scoreboard monitor
    always @(negedge SYSCLK) begin
        if (SYSRST === 1'b0 && bus.bit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_bit: got bit_valid=1 data=%0d expected no pulse (cycle %0d)",
                         bus.bit_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("bit_data", 32'(bus.bit_data), 32'(mon_e[32]));
                check("bit_time", 32'(cyc), mon_e[31:0]);
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got no end of test expected finish before 500000ns");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int lr, c, r, k;
        SYSRST = 1'b1;
        bus.DSDIN = 1'b0;
        bus.SDCLK = 1'b0;
        bus.reg_filtmode = 2'd0;
        bus.reg_filtdiv = 4'd3;
        bus.reg_filten = 1'b0;
        bus.reg_faultclr = 1'b0;
        tick(3);
        check("rst_bit_data", 32'(bus.bit_data), 32'd0);
        check("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
        check("rst_mclk", 32'(bus.MCLK_OUT), 32'd0);
        check("rst_fault", 32'(bus.clk_fault), 32'd0);
        check("rst_locked", 32'(bus.dbg_locked), 32'd0);

        SYSRST = 1'b0;
        bus.reg_filten = 1'b1;
        tick(2);

        // mode 0: bits 1,0,1,1 captured on rising edges
        clk_bits(0, 4'b1011, 4, lr);
        drain("mode0_drain");
        check("mode0_no_fault", 32'(bus.clk_fault), 32'd0);

        // mode 1: same stimulus, captured on falling edges
        bus.reg_filtmode = 2'd1;
        tick(2);
        clk_bits(1, 4'b1011, 4, lr);
        drain("mode1_drain");

        // mode 2, D=3: Manchester 1,0,0,1 from idle-low line
        bus.DSDIN = 1'b0;
        tick(4);
        bus.reg_filtmode = 2'd2;
        tick(4);
        drive_halves(8'b01101001, 8'b01010101, 8);
        tick(20);
        drain("mode2_drain");
        check("mode2_unlock", 32'(bus.dbg_locked), 32'd0);

        // mode 3, D=2: MCLK period 6, bits on MCLK fall
        bus.reg_filtdiv = 4'd2;
        bus.reg_filtmode = 2'd3;
        bus.DSDIN = 1'b1;
        c = cyc;
        expect_bit(1'b1, c + 7);
        expect_bit(1'b1, c + 13);
        expect_bit(1'b1, c + 19);
        expect_bit(1'b1, c + 25);
        wait_cyc(c + 3);
        check("mode3_mclk_low", 32'(bus.MCLK_OUT), 32'd0);
        tick(1);
        check("mode3_mclk_rise", 32'(bus.MCLK_OUT), 32'd1);
        bus.reg_faultclr = 1'b1;
        tick(1);
        bus.reg_faultclr = 1'b0;
        wait_cyc(c + 7);
        check("mode3_mclk_fall", 32'(bus.MCLK_OUT), 32'd0);
        wait_cyc(c + 27);
        check("mode3_no_fault", 32'(bus.clk_fault), 32'd0);
        bus.reg_filten = 1'b0;
        bus.reg_filtmode = 2'd0;
        bus.reg_filtdiv = 4'd3;
        tick(2);
        check("disable_mclk", 32'(bus.MCLK_OUT), 32'd0);
        drain("mode3_drain");

        // fault: SDCLK stops after bits 0,1
        bus.reg_filten = 1'b1;
        clk_bits(0, 4'b0001, 2, lr);
        wait_cyc(lr + 19);
        check("fault_before_timeout", 32'(bus.clk_fault), 32'd0);
        tick(1);
        check("fault_at_timeout", 32'(bus.clk_fault), 32'd1);
        wait_cyc(lr + 22);
        bus.reg_faultclr = 1'b1;
        tick(1);
        bus.reg_faultclr = 1'b0;
        check("fault_set_beats_clr", 32'(bus.clk_fault), 32'd1);
        bus.SDCLK = 1'b1;
        r = cyc;
        expect_bit(1'b1, r + 3);
        wait_cyc(r + 3);
        bus.reg_faultclr = 1'b1;
        tick(1);
        bus.reg_faultclr = 1'b0;
        check("fault_cleared", 32'(bus.clk_fault), 32'd0);
        clk_bits(0, 4'b0010, 2, lr);
        drain("fault_resume_drain");
        check("fault_stays_clear", 32'(bus.clk_fault), 32'd0);

        // mode change 0 -> 2 while a bit is in flight
        bus.DSDIN = 1'b0;
        tick(4);
        bus.SDCLK = 1'b1;
        k = cyc;
        tick(2);
        bus.reg_filtmode = 2'd2;
        tick(1);
        check("change_suppress", 32'(bus.bit_valid), 32'd0);
        check("change_unlocked", 32'(bus.dbg_locked), 32'd0);
        tick(4);
        drive_halves(8'b00000110, 8'b00000101, 4);
        tick(4);
        drain("change_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
